axi_slave_write_ctrl: RTL and testbench
=======================================

Name: axi_slave_write_ctrl

Overview:
- Slave-side AXI write engine for a memory-backed slave wrapper (SRAM/DRAM-style, 32-bit word memory).
- Accepts one AW request, absorbs its W burst, issues byte-masked word writes to the memory port, then returns a B response.
- The B output feeds directly into the interconnect's write-response channel mux, on that mux's per-slave ids/resp/valid/ready inputs.
- Only one outstanding write at a time.

Parameters:
- MEM_ADDR_BITS, 14, width of the memory word address; the word address is awaddr[MEM_ADDR_BITS+1:2].

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- awid_i  in  `AXI_IDS_BITS (8)  extended ID: {master, id}.
- awaddr_i  in  `AXI_ADDR_BITS (32)  start byte address.
- awlen_i  in  `AXI_LEN_BITS (4)  beats minus 1.
- awsize_i  in  `AXI_SIZE_BITS (3)  beat size.
- awburst_i  in  2  burst type.
- awvalid_i  in  1  AW valid.
- awready_o  out  1  AW ready.
- wdata_i  in  32  write data.
- wstrb_i  in  4  byte strobes.
- wlast_i  in  1  last beat.
- wvalid_i  in  1  W valid.
- wready_o  out  1  W ready.
- bid_o  out  `AXI_IDS_BITS (8)  response ID.
- bresp_o  out  `AXI_RESP_BITS (2)  response code.
- bvalid_o  out  1  B valid.
- bready_i  in  1  B ready.
- mem_cs_o  out  1  memory chip select, one cycle per accepted beat.
- mem_we_o  out  4  byte write enables, active-high.
- mem_addr_o  out  MEM_ADDR_BITS  word address.
- mem_di_o  out  32  write data.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: state=IDLE and all latched fields cleared. awready_o=0, wready_o=0, bvalid_o=0, bid_o=0, bresp_o=0, mem_cs_o=0 and mem_we_o=0 while rst is high.
- States: IDLE, DATA, RESP.
- IDLE:
  - awready_o=1.
  - On awvalid_i&awready_o, latch awid, word address, awlen and awburst; clear the beat counter and the error flag; go to DATA.
  - Set the error flag if awsize_i!=3'b010 or awburst_i is not FIXED (2'b00) or INCR (2'b01).
- DATA:
  - wready_o=1. Each beat is accepted on wvalid_i&wready_o.
  - mem_cs_o, mem_we_o, mem_addr_o and mem_di_o are combinational in the accepting cycle.
  - mem_we_o=wstrb_i only when the error flag is clear; otherwise mem_cs_o=0 and mem_we_o=0, and the data is absorbed.
  - After each beat: INCR increments the word address by 1, wrapping modulo 2^MEM_ADDR_BITS; FIXED holds the address. The beat counter increments.
  - The burst ends on the first accepted beat where wlast_i=1 OR beat counter==awlen.
  - wlast_i disagreeing with (counter==awlen) on the ending beat sets the error flag.
  - On the ending beat, go to RESP.
- RESP:
  - bvalid_o=1 (registered), bid_o=latched awid, bresp_o = error flag ? SLVERR (2'b10) : OKAY (2'b00).
  - bid_o and bresp_o are held stable until bready_i. On bvalid_o&bready_i, go to IDLE.
  - awready_o=0 and wready_o=0 in RESP.
- Latency:
  - AW handshake at cycle N: wready_o=1 at N+1.
  - Ending W beat at cycle M: bvalid_o=1 at M+1.
  - B handshake at cycle K: awready_o=1 at K+1.
  - The minimum single-beat transaction is 3 cycles.
- Simultaneous AW and W valid in IDLE: only AW is accepted; W stalls (wready_o=0) until DATA.
- wvalid_i low in DATA: no memory access; state and counters hold.
- bready_i tied high: bvalid_o stays high exactly one cycle.
- rst mid-burst or mid-RESP: the transaction is dropped, no B is issued, and the memory is untouched after the reset cycle.

Decomposition:
- Add to the shared AXI_define.svh:
  - `AXI_RESP_OKAY=2'b00, `AXI_RESP_SLVERR=2'b10.
  - `AXI_BURST_FIXED=2'b00, `AXI_BURST_INCR=2'b01.
  - `AXI_SIZE_WORD=3'b010.
- The state enum lives locally in the module.
- One natural sub-module: axi_burst_addr_gen. It holds the word-address register, FIXED/INCR step, beat counter and end-of-burst/length-mismatch detection. It is reusable by the read-side controller.

Test Plan:
- INCR single beat: AW{id=8'h12, addr=32'h0000_0010, len=0, size=2, burst=INCR}, W{data=32'hDEADBEEF, strb=4'hF, last=1}.
  -> One mem write: addr=4, we=4'hF. Then B{id=8'h12, resp=OKAY}, 1 cycle after the W beat.
- INCR len=3 at addr 32'h0000_FFF8 (word 16382), strb=4'h3, wvalid toggled every other cycle.
  -> Writes to words 16382, 16383, 0, 1 with we=4'h3. Bubbles produce no mem_cs. Single OKAY B.
- FIXED len=2 at addr 32'h20.
  -> All 3 writes at word 8. B OKAY.
- Error cases:
  - awsize=3'b001 -> data absorbed, mem_cs never asserted, bresp=SLVERR.
  - len=3 with wlast=1 on the 2nd beat -> 2 writes, then SLVERR.
- Backpressure: bready_i low for 5 cycles.
  -> bvalid_o, bid_o and bresp_o stable. A second AW presented meanwhile is not accepted until the cycle after the B handshake.
- rst asserted after the 1st of 4 beats.
  -> Next cycle: IDLE, awready=1, bvalid=0. No further mem writes. A fresh transaction completes normally.

Source files
------------

// File: rtl/axi_slave_write_ctrl_pkg.sv
// Shared AXI field widths, encodings and payload types for the slave write path.
package axi_slave_write_ctrl_pkg;

  localparam int unsigned AXI_IDS_BITS   = 8;
  localparam int unsigned AXI_ADDR_BITS  = 32;
  localparam int unsigned AXI_LEN_BITS   = 4;
  localparam int unsigned AXI_SIZE_BITS  = 3;
  localparam int unsigned AXI_BURST_BITS = 2;
  localparam int unsigned AXI_RESP_BITS  = 2;
  localparam int unsigned AXI_DATA_BITS  = 32;
  localparam int unsigned AXI_STRB_BITS  = AXI_DATA_BITS / 8;

  localparam logic [AXI_RESP_BITS-1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_BITS-1:0]  AXI_RESP_SLVERR = 2'b10;
  localparam logic [AXI_BURST_BITS-1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_BITS-1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [AXI_SIZE_BITS-1:0]  AXI_SIZE_WORD   = 3'b010;

  // Write-response payload held while B is pending.
  typedef struct packed {
    logic [AXI_IDS_BITS-1:0]  id;
    logic [AXI_RESP_BITS-1:0] resp;
  } b_rsp_t;

  // Only full-word FIXED/INCR bursts can be mapped onto the word memory.
  function automatic logic aw_unsupported(input logic [AXI_SIZE_BITS-1:0]  size,
                                          input logic [AXI_BURST_BITS-1:0] burst);
    return (size != AXI_SIZE_WORD) ||
           !((burst == AXI_BURST_FIXED) || (burst == AXI_BURST_INCR));
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Word-address sequencer for one AXI burst: FIXED/INCR stepping, beat count,
// end-of-burst and length-mismatch detection.
module axi_burst_addr_gen
  import axi_slave_write_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [ADDR_BITS-1:0]      start_addr,
  input  logic [AXI_LEN_BITS-1:0]   len,
  input  logic [AXI_BURST_BITS-1:0] burst,
  input  logic                      step,
  input  logic                      last,
  output logic [ADDR_BITS-1:0]      addr,
  output logic                      burst_end_c,
  output logic                      len_err_c
);

  logic [ADDR_BITS-1:0]      addr_q;
  logic [AXI_LEN_BITS-1:0]   cnt_q;
  logic [AXI_LEN_BITS-1:0]   len_q;
  logic [AXI_BURST_BITS-1:0] burst_q;
  logic                      cnt_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      burst_q <= '0;
    end else if (load) begin
      addr_q  <= start_addr;
      cnt_q   <= '0;
      len_q   <= len;
      burst_q <= burst;
    end else if (step) begin
      // INCR wraps naturally at the top of the word space; FIXED holds.
      if (burst_q == AXI_BURST_INCR) begin
        addr_q <= addr_q + ADDR_BITS'(1);
      end
      cnt_q <= cnt_q + AXI_LEN_BITS'(1);
    end
  end

  assign cnt_hit     = (cnt_q == len_q);
  assign addr        = addr_q;
  assign burst_end_c = step & (last | cnt_hit);
  assign len_err_c   = burst_end_c & (last ^ cnt_hit);

endmodule

// File: rtl/axi_slave_write_ctrl.sv
// Single-outstanding AXI write slave: AW accept, W burst to byte-masked
// word memory writes, then one B response.
module axi_slave_write_ctrl
  import axi_slave_write_ctrl_pkg::*;
#(
  parameter int unsigned MEM_ADDR_BITS = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_IDS_BITS-1:0]   awid_i,
  input  logic [AXI_ADDR_BITS-1:0]  awaddr_i,
  input  logic [AXI_LEN_BITS-1:0]   awlen_i,
  input  logic [AXI_SIZE_BITS-1:0]  awsize_i,
  input  logic [AXI_BURST_BITS-1:0] awburst_i,
  input  logic                      awvalid_i,
  output logic                      awready_o,
  input  logic [AXI_DATA_BITS-1:0]  wdata_i,
  input  logic [AXI_STRB_BITS-1:0]  wstrb_i,
  input  logic                      wlast_i,
  input  logic                      wvalid_i,
  output logic                      wready_o,
  output logic [AXI_IDS_BITS-1:0]   bid_o,
  output logic [AXI_RESP_BITS-1:0]  bresp_o,
  output logic                      bvalid_o,
  input  logic                      bready_i,
  output logic                      mem_cs_o,
  output logic [AXI_STRB_BITS-1:0]  mem_we_o,
  output logic [MEM_ADDR_BITS-1:0]  mem_addr_o,
  output logic [AXI_DATA_BITS-1:0]  mem_di_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [AXI_IDS_BITS-1:0]  id_q;
  logic                     err_q;
  logic                     aw_hs;
  logic                     w_hs;
  logic                     burst_end_c;
  logic                     len_err_c;
  logic [MEM_ADDR_BITS-1:0] word_addr;
  b_rsp_t                   b_rsp;
  logic                     unused_awaddr;

  // Handshakes are suppressed during reset so nothing is accepted that cycle.
  assign aw_hs = ~rst & (state_q == IDLE) & awvalid_i;
  assign w_hs  = ~rst & (state_q == DATA) & wvalid_i;

  // Only the word-address slice of awaddr reaches the memory.
  assign unused_awaddr = ^awaddr_i;

  axi_burst_addr_gen #(
    .ADDR_BITS (MEM_ADDR_BITS)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .load        (aw_hs),
    .start_addr  (awaddr_i[MEM_ADDR_BITS+1:2]),
    .len         (awlen_i),
    .burst       (awburst_i),
    .step        (w_hs),
    .last        (wlast_i),
    .addr        (word_addr),
    .burst_end_c (burst_end_c),
    .len_err_c   (len_err_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    mem_cs_o  = 1'b0;
    mem_we_o  = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          awready_o = 1'b1;
          if (aw_hs) begin
            state_d = DATA;
          end
        end
        DATA: begin
          wready_o = 1'b1;
          if (w_hs) begin
            // Errored bursts are absorbed without touching memory.
            mem_cs_o = ~err_q;
            mem_we_o = err_q ? '0 : wstrb_i;
            if (burst_end_c) begin
              state_d = RESP;
            end
          end
        end
        RESP: begin
          bvalid_o = 1'b1;
          if (bready_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Transaction context: ID and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q  <= '0;
      err_q <= 1'b0;
    end else if (aw_hs) begin
      id_q  <= awid_i;
      err_q <= aw_unsupported(awsize_i, awburst_i);
    end else if (len_err_c) begin
      err_q <= 1'b1;
    end
  end

  assign b_rsp.id   = id_q;
  assign b_rsp.resp = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

  assign bid_o      = bvalid_o ? b_rsp.id   : '0;
  assign bresp_o    = bvalid_o ? b_rsp.resp : '0;
  assign mem_addr_o = word_addr;
  assign mem_di_o   = wdata_i;

endmodule

// File: tb/tb_axi_slave_write_ctrl.sv
// Directed self-checking bench for axi_slave_write_ctrl.
module tb_axi_slave_write_ctrl;
  import axi_slave_write_ctrl_pkg::*;

  localparam int unsigned MAB = 14;

  typedef struct packed {
    logic [MAB-1:0] addr;
    logic [3:0]     we;
    logic [31:0]    data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        mem_cs;
  logic [3:0]  mem_we;
  logic [MAB-1:0] mem_addr;
  logic [31:0] mem_di;

  int errors = 0;
  int checks = 0;
  wr_t got_q[$];
  wr_t exp_q[$];

  always #5 clk = ~clk;

  axi_slave_write_ctrl #(.MEM_ADDR_BITS(MAB)) dut (
    .clk        (clk),
    .rst        (rst),
    .awid_i     (awid),
    .awaddr_i   (awaddr),
    .awlen_i    (awlen),
    .awsize_i   (awsize),
    .awburst_i  (awburst),
    .awvalid_i  (awvalid),
    .awready_o  (awready),
    .wdata_i    (wdata),
    .wstrb_i    (wstrb),
    .wlast_i    (wlast),
    .wvalid_i   (wvalid),
    .wready_o   (wready),
    .bid_o      (bid),
    .bresp_o    (bresp),
    .bvalid_o   (bvalid),
    .bready_i   (bready),
    .mem_cs_o   (mem_cs),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_di_o   (mem_di)
  );

  // Memory-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_cs) got_q.push_back({mem_addr, mem_we, mem_di});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input logic [MAB-1:0] a, input logic [3:0] we, input logic [31:0] d);
    exp_q.push_back({a, we, d});
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, ".count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(tag, 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic aw_start(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    #1;
    chk("awready", 64'(awready), 64'(1));
    tick();
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic last);
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    #1;
    chk("wready", 64'(wready), 64'(1));
    tick();
    wvalid = 1'b0;
  endtask

  task automatic check_b(input logic [7:0] id, input logic [1:0] resp);
    chk("bvalid", 64'(bvalid), 64'(1));
    chk("bid", 64'(bid), 64'(id));
    chk("bresp", 64'(bresp), 64'(resp));
  endtask

  task automatic b_accept();
    bready = 1'b1;
    #1;
    tick();
    bready = 1'b0;
    chk("bvalid_drop", 64'(bvalid), 64'(0));
    chk("awready_back", 64'(awready), 64'(1));
  endtask

  initial begin
    rst = 1'b1; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst.awready", 64'(awready), 64'(0));
    chk("rst.wready", 64'(wready), 64'(0));
    chk("rst.bvalid", 64'(bvalid), 64'(0));
    chk("rst.bid", 64'(bid), 64'(0));
    chk("rst.bresp", 64'(bresp), 64'(0));
    chk("rst.mem_cs", 64'(mem_cs), 64'(0));
    chk("rst.mem_we", 64'(mem_we), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst.awready", 64'(awready), 64'(1));
    got_q.delete();

    // INCR single beat
    aw_start(8'h12, 32'h0000_0010, 4'd0, 3'b010, 2'b01);
    w_beat(32'hDEAD_BEEF, 4'hF, 1'b1);
    check_b(8'h12, 2'b00);
    chk("t1.wready_resp", 64'(wready), 64'(0));
    b_accept();
    exp_wr(14'd4, 4'hF, 32'hDEAD_BEEF);
    compare_writes("t1.wr");

    // INCR len=3 across the top of the word space, with bubbles
    aw_start(8'h21, 32'h0000_FFF8, 4'd3, 3'b010, 2'b01);
    for (int i = 0; i < 4; i++) begin
      w_beat(32'h1111_1111 * (i + 1), 4'h3, (i == 3));
      if (i < 3) begin
        #1;
        chk("t2.bubble_cs", 64'(mem_cs), 64'(0));
        tick();
      end
    end
    check_b(8'h21, 2'b00);
    b_accept();
    exp_wr(14'd16382, 4'h3, 32'h1111_1111);
    exp_wr(14'd16383, 4'h3, 32'h2222_2222);
    exp_wr(14'd0,     4'h3, 32'h3333_3333);
    exp_wr(14'd1,     4'h3, 32'h4444_4444);
    compare_writes("t2.wr");

    // FIXED len=2
    aw_start(8'h31, 32'h0000_0020, 4'd2, 3'b010, 2'b00);
    w_beat(32'hA000_0001, 4'hF, 1'b0);
    w_beat(32'hA000_0002, 4'h1, 1'b0);
    w_beat(32'hA000_0003, 4'h8, 1'b1);
    check_b(8'h31, 2'b00);
    b_accept();
    exp_wr(14'd8, 4'hF, 32'hA000_0001);
    exp_wr(14'd8, 4'h1, 32'hA000_0002);
    exp_wr(14'd8, 4'h8, 32'hA000_0003);
    compare_writes("t3.wr");

    // Unsupported size: absorbed, SLVERR
    aw_start(8'h33, 32'h0000_0040, 4'd1, 3'b001, 2'b01);
    w_beat(32'hBAD0_0001, 4'hF, 1'b0);
    w_beat(32'hBAD0_0002, 4'hF, 1'b1);
    check_b(8'h33, 2'b10);
    b_accept();
    compare_writes("t4.wr");

    // Early wlast on beat 2 of 4
    aw_start(8'h44, 32'h0000_0080, 4'd3, 3'b010, 2'b01);
    w_beat(32'hC000_0001, 4'hF, 1'b0);
    w_beat(32'hC000_0002, 4'hF, 1'b1);
    check_b(8'h44, 2'b10);
    chk("t5.wready_resp", 64'(wready), 64'(0));
    b_accept();
    exp_wr(14'd32, 4'hF, 32'hC000_0001);
    exp_wr(14'd33, 4'hF, 32'hC000_0002);
    compare_writes("t5.wr");

    // B backpressure with a second AW waiting
    aw_start(8'h5A, 32'h0000_0030, 4'd0, 3'b010, 2'b01);
    w_beat(32'h5A5A_5A5A, 4'hF, 1'b1);
    awid = 8'h6B; awaddr = 32'h0000_0040; awlen = 4'd0; awsize = 3'b010; awburst = 2'b01;
    awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_b(8'h5A, 2'b00);
      chk("t6.aw_blocked", 64'(awready), 64'(0));
      tick();
    end
    bready = 1'b1;
    #1;
    chk("t6.aw_blocked_hs", 64'(awready), 64'(0));
    tick();
    bready = 1'b0;
    chk("t6.bvalid_drop", 64'(bvalid), 64'(0));
    chk("t6.aw_accept", 64'(awready), 64'(1));
    tick();
    awvalid = 1'b0;
    w_beat(32'h6B6B_6B6B, 4'hF, 1'b1);
    check_b(8'h6B, 2'b00);
    b_accept();
    exp_wr(14'd12, 4'hF, 32'h5A5A_5A5A);
    exp_wr(14'd16, 4'hF, 32'h6B6B_6B6B);
    compare_writes("t6.wr");

    // Reset after the first of four beats
    aw_start(8'h77, 32'h0000_0100, 4'd3, 3'b010, 2'b01);
    w_beat(32'hE000_0001, 4'hF, 1'b0);
    rst = 1'b1; wdata = 32'hE000_0002; wvalid = 1'b1;
    #1;
    chk("t7.rst_cs", 64'(mem_cs), 64'(0));
    chk("t7.rst_wready", 64'(wready), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("t7.awready", 64'(awready), 64'(1));
    chk("t7.bvalid", 64'(bvalid), 64'(0));
    chk("t7.wready", 64'(wready), 64'(0));
    tick();
    wvalid = 1'b0;
    exp_wr(14'd64, 4'hF, 32'hE000_0001);
    compare_writes("t7.wr");

    // Fresh transaction after reset
    aw_start(8'h88, 32'h0000_0008, 4'd1, 3'b010, 2'b01);
    w_beat(32'hF000_0001, 4'hC, 1'b0);
    w_beat(32'hF000_0002, 4'h3, 1'b1);
    check_b(8'h88, 2'b00);
    b_accept();
    exp_wr(14'd2, 4'hC, 32'hF000_0001);
    exp_wr(14'd3, 4'h3, 32'hF000_0002);
    compare_writes("t8.wr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
